bcd_step_commander: RTL and testbench
=====================================

// Module: bcd_step_commander
// PURPOSE
//  Command initiator for the 2-bit decade step counter: drives cmd codes
//  00=hold, 01=+1, 10=+2, 11=-1 plus a one-cycle step strobe.
//  On start it moves the counter from its current digit to a target digit
//  (0-9) along the shortest path on the mod-10 ring, then reports done.
//  It keeps an internal mirror of the counter digit. It sits between the
//  switch/key front end and the counter, and drives the counter's command
//  inputs and step clock.
// PARAMETERS
//  INIT_DIGIT  0  mirror value after reset or sync_clr (0-9)
//  STEP_GAP    3  idle cycles between consecutive step pulses (0-15)
// PORTS
//  CLK        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-high reset
//  start      in   1  request move; sampled only in IDLE
//  target     in   4  destination digit; sampled with start
//  sync_clr   in   1  counter was cleared: mirror<=INIT_DIGIT, abort to IDLE
//  cmd        out  2  command code; non-zero only while step=1, else 2'b00
//  step       out  1  one-cycle strobe; counter applies cmd on it
//  busy       out  1  high in every state except IDLE
//  done       out  1  one-cycle pulse when the mirror equals target
//  err        out  1  target>9 at start; held until the next accepted start
//  cur_digit  out  4  mirror digit, 0-9
// BEHAVIOUR
//  Reset: state=IDLE, cur_digit=INIT_DIGIT, cmd=00, step=0, busy=0,
//   done=0, err=0.
//  States: IDLE, PLAN, ISSUE, GAP, DONE.
//  IDLE:  start=1 -> latch target and clear err.
//         target>9 -> set err, stay IDLE, issue no steps and no done.
//         Otherwise -> PLAN.
//  PLAN (1 cycle): compute d=(target-cur) mod 10 and b=(10-d) mod 10.
//         d==0 -> DONE.
//         ceil(d/2)<=b -> direction FWD, else BWD.
//         Direction is fixed until DONE; there is no replanning.
//         Go to ISSUE.
//  ISSUE (1 cycle): step=1.
//         FWD: cmd=10 if remaining>=2, else 01.
//         BWD: cmd=11.
//         At the end of the cycle, update the mirror with mod-10 wrap:
//         +2 maps 8->0 and 9->1; +1 maps 9->0; -1 maps 0->9.
//         Next state: DONE if the new mirror==target; else GAP if
//         STEP_GAP>0; else ISSUE.
//  GAP:   STEP_GAP cycles, cmd=00, step=0, then ISSUE.
//         Step pulses are spaced STEP_GAP+1 cycles apart.
//  DONE (1 cycle): done=1, busy=1; then IDLE.
//  Latency: with start high at edge E0, PLAN occupies cycle E0..E1 and the
//   first step is high in cycle E1..E2.
//  start while busy is ignored and not queued.
//  sync_clr has priority over start and over every state: next edge gives
//   mirror=INIT_DIGIT, state=IDLE, no done. err is unchanged.
//  Asynchronous reset mid-move: step/cmd drop immediately; no done.
//  cur_digit never leaves 0-9. All arithmetic is 4-bit, with explicit
//   mod-10 correction.
// TESTING
//  cur=3, start target=7 -> cmd 10,10; cur 5,7; 2 steps; done once.
//  cur=7, target=3 -> FWD (3 vs 4): cmd 10 x3, cur 9,1,3.
//  cur=2, target=1 -> single cmd 11, cur=1.
//  cur=0, target=5 -> cmd 10,10,01.
//  STEP_GAP=3: step pulses exactly 4 cycles apart; cmd=00 between steps.
//  target=12 -> err=1, busy stays 0, no step; next valid start clears err.
//  sync_clr during 2nd GAP -> IDLE, cur=INIT_DIGIT, no done.
//  Async reset mid-move -> all outputs at reset values immediately.
//  start with target==cur -> PLAN then DONE, zero steps, done pulse.

Source files
------------

// File: rtl/bcd_step_commander_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_step_commander_if
// Purpose  : Request/command bundle between the key front end, the step
//            commander and the decade step counter.
//   master : drives start/target/sync_clr, observes the command outputs
//   slave  : the commander itself
// Signals  : start, target[3:0], sync_clr       (requests)
//            cmd[1:0], step, busy, done, err,    (commander outputs)
//            cur_digit[3:0]
// Revision : 1.0  initial release
// ============================================================================
interface bcd_step_commander_if;
  logic       start;
  logic [3:0] target;
  logic       sync_clr;
  logic [1:0] cmd;
  logic       step;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] cur_digit;

  modport master (
    output start, target, sync_clr,
    input  cmd, step, busy, done, err, cur_digit
  );

  modport slave (
    input  start, target, sync_clr,
    output cmd, step, busy, done, err, cur_digit
  );
endinterface
`default_nettype wire

// File: rtl/bcd_step_commander.sv
`default_nettype none
// ============================================================================
// Module   : bcd_step_commander
// Purpose  : Moves a 2-bit-commanded decade counter from its current digit
//            to a requested digit along the shortest mod-10 path, keeping a
//            mirror of the counter digit, then pulses done.
// Ports    : CLK       clock, rising edge
//            reset     asynchronous active-high reset
//            bus       slave side of bcd_step_commander_if
//              start/target/sync_clr in; cmd/step/busy/done/err/cur_digit out
// Params   : INIT_DIGIT  mirror value after reset or sync_clr (0-9)
//            STEP_GAP    idle cycles between consecutive steps (0-15)
// Revision : 1.0  initial release
// ============================================================================
module bcd_step_commander #(
  parameter int INIT_DIGIT = 0,
  parameter int STEP_GAP   = 3
) (
  input  wire logic              CLK,
  input  wire logic              reset,
  bcd_step_commander_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAN  = 3'd1,
    S_ISSUE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] c_cmd_hold = 2'b00;
  localparam logic [1:0] c_cmd_inc1 = 2'b01;
  localparam logic [1:0] c_cmd_inc2 = 2'b10;
  localparam logic [1:0] c_cmd_dec1 = 2'b11;
  localparam logic [3:0] c_init     = 4'(INIT_DIGIT);
  localparam logic       c_has_gap  = (STEP_GAP > 0);
  localparam logic [3:0] c_gap_last = (STEP_GAP > 0) ? 4'(STEP_GAP - 1) : 4'd0;

  state_t     r_state, w_state;
  logic [3:0] r_cur, w_cur;
  logic [3:0] r_target, w_target;
  logic       r_err, w_err;
  logic       r_bwd, w_bwd;
  logic [3:0] r_gap_cnt, w_gap_cnt;

  logic [3:0] w_diff_raw;
  logic [3:0] w_fwd_dist;
  logic [3:0] w_bwd_dist;
  logic [3:0] w_half_fwd;
  logic [1:0] w_issue_cmd;
  logic [3:0] w_cur_stepped;

  // Ring distances from the mirror to the latched target. The 4-bit
  // subtraction wraps mod 16 when target < cur; removing 6 folds it to mod 10.
  always_comb begin
    w_diff_raw = r_target - r_cur;
    w_fwd_dist = (r_target >= r_cur) ? w_diff_raw : (w_diff_raw - 4'd6);
    w_bwd_dist = (w_fwd_dist == 4'd0) ? 4'd0 : (4'd10 - w_fwd_dist);
    // Forward moves cover two digits per step, so cost is ceil(d/2).
    w_half_fwd = (w_fwd_dist + 4'd1) >> 1;
  end

  // Command for the current step; the forward distance doubles as the
  // remaining count since the mirror tracks every issued step.
  always_comb begin
    if (r_bwd) begin
      w_issue_cmd = c_cmd_dec1;
    end else if (w_fwd_dist >= 4'd2) begin
      w_issue_cmd = c_cmd_inc2;
    end else begin
      w_issue_cmd = c_cmd_inc1;
    end
  end

  // Mirror value after applying the step command, with explicit wrap.
  always_comb begin
    w_cur_stepped = r_cur;
    case (w_issue_cmd)
      c_cmd_inc2: w_cur_stepped = (r_cur >= 4'd8) ? (r_cur - 4'd8) : (r_cur + 4'd2);
      c_cmd_inc1: w_cur_stepped = (r_cur == 4'd9) ? 4'd0 : (r_cur + 4'd1);
      c_cmd_dec1: w_cur_stepped = (r_cur == 4'd0) ? 4'd9 : (r_cur - 4'd1);
      default:    w_cur_stepped = r_cur;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    w_state   = r_state;
    w_cur     = r_cur;
    w_target  = r_target;
    w_err     = r_err;
    w_bwd     = r_bwd;
    w_gap_cnt = r_gap_cnt;

    if (bus.sync_clr) begin
      // Counter was cleared externally: resynchronise and abandon the move.
      w_state = S_IDLE;
      w_cur   = c_init;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_target = bus.target;
            if (bus.target > 4'd9) begin
              w_err = 1'b1;
            end else begin
              w_err   = 1'b0;
              w_state = S_PLAN;
            end
          end
        end
        S_PLAN: begin
          if (w_fwd_dist == 4'd0) begin
            w_state = S_DONE;
          end else begin
            w_bwd   = (w_half_fwd > w_bwd_dist);
            w_state = S_ISSUE;
          end
        end
        S_ISSUE: begin
          w_cur = w_cur_stepped;
          if (w_cur_stepped == r_target) begin
            w_state = S_DONE;
          end else if (c_has_gap) begin
            w_gap_cnt = c_gap_last;
            w_state   = S_GAP;
          end else begin
            w_state = S_ISSUE;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            w_state = S_ISSUE;
          end else begin
            w_gap_cnt = r_gap_cnt - 4'd1;
          end
        end
        S_DONE: begin
          w_state = S_IDLE;
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cur     <= c_init;
      r_target  <= 4'd0;
      r_err     <= 1'b0;
      r_bwd     <= 1'b0;
      r_gap_cnt <= 4'd0;
    end else begin
      r_state   <= w_state;
      r_cur     <= w_cur;
      r_target  <= w_target;
      r_err     <= w_err;
      r_bwd     <= w_bwd;
      r_gap_cnt <= w_gap_cnt;
    end
  end

  // Outputs decode directly from the state register so an asynchronous
  // reset removes step/cmd/done without waiting for a clock.
  assign bus.step      = (r_state == S_ISSUE);
  assign bus.cmd       = (r_state == S_ISSUE) ? w_issue_cmd : c_cmd_hold;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = r_err;
  assign bus.cur_digit = r_cur;

endmodule
`default_nettype wire

// File: tb/tb_bcd_step_commander.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_step_commander
// Purpose  : Self-checking bench for bcd_step_commander. A ring-arithmetic
//            reference builds the expected per-cycle output timeline of each
//            move; directed cases are followed by randomized moves.
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_step_commander;

  localparam int INIT_DIGIT = 3;
  localparam int STEP_GAP   = 3;

  typedef struct packed {
    logic       busy;
    logic       step;
    logic [1:0] cmd;
    logic       done;
    logic [3:0] cur;
  } exp_t;

  logic CLK;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   m_cur;
  logic exp_err;

  bcd_step_commander_if bus();

  bcd_step_commander #(
    .INIT_DIGIT (INIT_DIGIT),
    .STEP_GAP   (STEP_GAP)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e, input logic e_err);
    chk({tag, ".busy"}, 32'(bus.busy),      32'(e.busy));
    chk({tag, ".step"}, 32'(bus.step),      32'(e.step));
    chk({tag, ".cmd"},  32'(bus.cmd),       32'(e.cmd));
    chk({tag, ".done"}, 32'(bus.done),      32'(e.done));
    chk({tag, ".cur"},  32'(bus.cur_digit), 32'(e.cur));
    chk({tag, ".err"},  32'(bus.err),       32'(e_err));
  endtask

  function automatic exp_t mk(input logic b, input logic s, input logic [1:0] c,
                              input logic d, input int cur);
    exp_t e;
    e.busy = b; e.step = s; e.cmd = c; e.done = d; e.cur = 4'(cur);
    return e;
  endfunction

  // One move request. inj_at: timeline index at which a stray start is
  // raised (must be ignored). clr_at / rst_at: index at which sync_clr or
  // the asynchronous reset interrupts the move. -1 disables each.
  task automatic run_move(input string tag, input int tgt, input int inj_at,
                          input int clr_at, input int rst_at);
    exp_t tl[$];
    int   c, d, b, rem, s;
    bit   fwd;

    @(negedge CLK);
    bus.start  = 1'b1;
    bus.target = 4'(tgt);
    @(posedge CLK);
    #1 bus.start = 1'b0;

    if (tgt > 9) begin
      exp_err = 1'b1;
      repeat (3) begin
        @(negedge CLK);
        chk_all({tag, ".err_idle"}, mk(1'b0, 1'b0, 2'b00, 1'b0, m_cur), exp_err);
      end
      return;
    end
    exp_err = 1'b0;

    // Reference plan from ring arithmetic.
    c   = m_cur;
    d   = (tgt - c + 10) % 10;
    b   = (10 - d) % 10;
    fwd = ((d + 1) / 2) <= b;
    tl.push_back(mk(1'b1, 1'b0, 2'b00, 1'b0, c));
    rem = fwd ? d : b;
    while (rem > 0) begin
      if (fwd) begin
        s = (rem >= 2) ? 2 : 1;
        tl.push_back(mk(1'b1, 1'b1, (s == 2) ? 2'b10 : 2'b01, 1'b0, c));
        c = (c + s) % 10;
      end else begin
        s = 1;
        tl.push_back(mk(1'b1, 1'b1, 2'b11, 1'b0, c));
        c = (c + 9) % 10;
      end
      rem -= s;
      if (rem > 0) repeat (STEP_GAP) tl.push_back(mk(1'b1, 1'b0, 2'b00, 1'b0, c));
    end
    tl.push_back(mk(1'b1, 1'b0, 2'b00, 1'b1, c));

    for (int i = 0; i < tl.size(); i++) begin
      @(negedge CLK);
      bus.start = 1'b0;
      chk_all($sformatf("%s[%0d]", tag, i), tl[i], exp_err);
      if (i == inj_at) begin
        bus.start  = 1'b1;
        bus.target = 4'($urandom_range(0, 9));
      end
      if (i == clr_at) begin
        bus.sync_clr = 1'b1;
        @(negedge CLK);
        bus.sync_clr = 1'b0;
        bus.start    = 1'b0;
        m_cur        = INIT_DIGIT;
        chk_all({tag, ".clr"}, mk(1'b0, 1'b0, 2'b00, 1'b0, m_cur), exp_err);
        @(negedge CLK);
        chk_all({tag, ".clr2"}, mk(1'b0, 1'b0, 2'b00, 1'b0, m_cur), exp_err);
        return;
      end
      if (i == rst_at) begin
        #2 reset = 1'b1;
        #1;
        m_cur   = INIT_DIGIT;
        exp_err = 1'b0;
        chk_all({tag, ".arst"}, mk(1'b0, 1'b0, 2'b00, 1'b0, m_cur), exp_err);
        @(negedge CLK);
        reset     = 1'b0;
        bus.start = 1'b0;
        chk_all({tag, ".arst2"}, mk(1'b0, 1'b0, 2'b00, 1'b0, m_cur), exp_err);
        return;
      end
    end
    @(negedge CLK);
    bus.start = 1'b0;
    m_cur     = tgt;
    chk_all({tag, ".idle"}, mk(1'b0, 1'b0, 2'b00, 1'b0, m_cur), exp_err);
  endtask

  initial begin
    int tgt, inj, clr, rst, r;
    n_tests      = 0;
    n_fail       = 0;
    m_cur        = INIT_DIGIT;
    exp_err      = 1'b0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.target   = 4'd0;
    bus.sync_clr = 1'b0;

    #2;
    chk_all("reset", mk(1'b0, 1'b0, 2'b00, 1'b0, INIT_DIGIT), 1'b0);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    chk_all("post_reset", mk(1'b0, 1'b0, 2'b00, 1'b0, INIT_DIGIT), 1'b0);

    run_move("3to7",     7, -1, -1, -1);   // +2,+2
    run_move("7to3",     3,  1, -1, -1);   // forward x3 across wrap, stray start
    run_move("3to2",     2, -1, -1, -1);   // single -1
    run_move("2to1",     1, -1, -1, -1);
    run_move("1to0",     0, -1, -1, -1);
    run_move("0to5clr",  5, -1,  6, -1);   // sync_clr in second gap
    run_move("badtgt",  12, -1, -1, -1);   // err set, no motion
    run_move("same",     3,  1, -1, -1);   // clears err, zero steps
    run_move("3to8rst",  8, -1, -1,  5);   // async reset during a step
    run_move("3to0",     0, -1, -1, -1);
    run_move("0to5",     5, -1, -1, -1);   // +2,+2,+1

    for (int k = 0; k < 40; k++) begin
      tgt = $urandom_range(0, 11);
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      r   = $urandom_range(0, 11);
      clr = (r == 0) ? int'($urandom_range(1, 8)) : -1;
      rst = (r == 1) ? int'($urandom_range(1, 8)) : -1;
      run_move($sformatf("rnd%0d", k), tgt, inj, clr, rst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
